// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// codes and the multiply/divide sequencer state encoding.
package hazard_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXE   = 2'b01;
  localparam logic [1:0] FWD_MEM   = 2'b10;
  localparam logic [1:0] FWD_MEMLD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/mdu_seq.sv
// Multiply/divide unit sequencer: tracks one operation in flight and pulses
// done in the final busy cycle.
module mdu_seq
  import hazard_pkg::*;
#(
  parameter int MDU_CYCLES = 8
) (
  input  logic clk,
  input  logic clrn,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam logic [4:0] CNT_INIT = 5'(MDU_CYCLES - 1);

  mdu_state_t state, state_next;
  logic [4:0] cnt, cnt_next;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The counter reaches zero in the last busy cycle, which is also the done cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = BUSY;
          cnt_next   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt == 5'd0) state_next = IDLE;
        else             cnt_next   = cnt - 5'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == BUSY);
  assign done = (state == BUSY) && (cnt == 5'd0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and interlock controller beside the ID stage: operand forwarding,
// load-use and MDU interlocks, branch squash and a stall-cycle counter.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_CYCLES  = 8,
  parameter int DELAY_SLOT  = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic [4:0]             rs,
  input  logic [4:0]             rt,
  input  logic                   use_rs,
  input  logic                   use_rt,
  input  logic                   ewreg,
  input  logic                   em2reg,
  input  logic [4:0]             ern,
  input  logic                   mwreg,
  input  logic                   mm2reg,
  input  logic [4:0]             mrn,
  input  logic                   dbranch,
  input  logic                   dmdu_start,
  input  logic                   dmdu_use,
  output logic [1:0]             fwda,
  output logic [1:0]             fwdb,
  output logic                   wpcir,
  output logic                   de_bubble,
  output logic                   if_flush,
  output logic                   mdu_busy,
  output logic                   mdu_done,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic FLUSH_EN = (DELAY_SLOT == 0);
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic lu_stall;
  logic mdu_stall;
  logic stall;
  logic mdu_start_ok;

  // EXE outranks MEM because it holds the younger write to the same register.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       e_wreg,
    input logic       e_m2reg,
    input logic [4:0] e_rn,
    input logic       m_wreg,
    input logic       m_m2reg,
    input logic [4:0] m_rn
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (src != 5'd0) begin
      if (e_wreg && !e_m2reg && (e_rn == src))      sel = FWD_EXE;
      else if (m_wreg && !m_m2reg && (m_rn == src)) sel = FWD_MEM;
      else if (m_wreg && m_m2reg && (m_rn == src))  sel = FWD_MEMLD;
    end
    return sel;
  endfunction

  always_comb begin
    fwda = fwd_sel(rs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
    fwdb = fwd_sel(rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
  end

  always_comb begin
    lu_stall  = ewreg && em2reg && (ern != 5'd0) &&
                ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));
    mdu_stall = mdu_busy && (dmdu_use || dmdu_start);
    stall     = lu_stall || mdu_stall;
    wpcir     = !stall;
    de_bubble = stall;
    if_flush  = FLUSH_EN && dbranch && !stall;
    mdu_start_ok = dmdu_start && !stall;
  end

  mdu_seq #(
    .MDU_CYCLES(MDU_CYCLES)
  ) u_mdu_seq (
    .clk  (clk),
    .clrn (clrn),
    .start(mdu_start_ok),
    .busy (mdu_busy),
    .done (mdu_done)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                             stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))   stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed steps followed by random
// traffic, all compared against an operation-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int MDU_CYC = 8;
  localparam int SCW     = 4;
  localparam int SAT     = 15;

  logic           clk = 1'b0;
  logic           clrn;
  logic [4:0]     rs, rt, ern, mrn;
  logic           use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg;
  logic           dbranch, dmdu_start, dmdu_use;
  logic [1:0]     fwda, fwdb;
  logic           wpcir, de_bubble, if_flush, mdu_busy, mdu_done;
  logic [SCW-1:0] stall_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int mRemaining  = 0;
  int mStallCnt   = 0;
  bit expStall    = 1'b0;

  pipe_hazard_ctrl #(
    .MDU_CYCLES (MDU_CYC),
    .DELAY_SLOT (0),
    .STALL_CNT_W(SCW)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .rs        (rs),
    .rt        (rt),
    .use_rs    (use_rs),
    .use_rt    (use_rt),
    .ewreg     (ewreg),
    .em2reg    (em2reg),
    .ern       (ern),
    .mwreg     (mwreg),
    .mm2reg    (mm2reg),
    .mrn       (mrn),
    .dbranch   (dbranch),
    .dmdu_start(dmdu_start),
    .dmdu_use  (dmdu_use),
    .fwda      (fwda),
    .fwdb      (fwdb),
    .wpcir     (wpcir),
    .de_bubble (de_bubble),
    .if_flush  (if_flush),
    .mdu_busy  (mdu_busy),
    .mdu_done  (mdu_done),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference forwarding: newest producer of a nonzero register wins.
  function automatic int refFwd(input logic [4:0] src);
    if (src == 5'd0) return 0;
    if (ewreg && !em2reg && ern == src) return 1;
    if (mwreg && mrn == src) return mm2reg ? 3 : 2;
    return 0;
  endfunction

  task automatic applyStimulus(
    input logic [4:0] a_rs, input logic [4:0] a_rt,
    input logic a_use_rs, input logic a_use_rt,
    input logic a_ewreg, input logic a_em2reg, input logic [4:0] a_ern,
    input logic a_mwreg, input logic a_mm2reg, input logic [4:0] a_mrn,
    input logic a_branch, input logic a_start, input logic a_use
  );
    rs = a_rs; rt = a_rt; use_rs = a_use_rs; use_rt = a_use_rt;
    ewreg = a_ewreg; em2reg = a_em2reg; ern = a_ern;
    mwreg = a_mwreg; mm2reg = a_mm2reg; mrn = a_mrn;
    dbranch = a_branch; dmdu_start = a_start; dmdu_use = a_use;
  endtask

  task automatic checkOutput(input string tag);
    bit lu, busy, done, st;
    #1;
    if (!clrn) begin
      mRemaining = 0;
      mStallCnt  = 0;
    end
    busy = (mRemaining > 0);
    done = (mRemaining == 1);
    lu   = ewreg && em2reg && (ern != 5'd0) &&
           ((use_rs && ern == rs) || (use_rt && ern == rt));
    st   = lu || (busy && (dmdu_use || dmdu_start));
    expStall = st;
    cmp({tag, ".fwda"},      32'(fwda),      refFwd(rs));
    cmp({tag, ".fwdb"},      32'(fwdb),      refFwd(rt));
    cmp({tag, ".wpcir"},     32'(wpcir),     32'(!st));
    cmp({tag, ".de_bubble"}, 32'(de_bubble), 32'(st));
    cmp({tag, ".if_flush"},  32'(if_flush),  32'(dbranch && !st));
    cmp({tag, ".mdu_busy"},  32'(mdu_busy),  32'(busy));
    cmp({tag, ".mdu_done"},  32'(mdu_done),  32'(done));
    cmp({tag, ".stall_cnt"}, 32'(stall_cnt), mStallCnt);
  endtask

  task automatic advance();
    @(posedge clk);
    if (clrn) begin
      if (mRemaining > 0) mRemaining--;
      else if (dmdu_start && !expStall) mRemaining = MDU_CYC;
      if (expStall && mStallCnt < SAT) mStallCnt++;
    end
    @(negedge clk);
  endtask

  task automatic cycle(input string tag);
    checkOutput(tag);
    advance();
  endtask

  initial begin
    clrn = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cycle("reset");
    clrn = 1'b1;

    applyStimulus(5, 5, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0);
    cycle("fwd_exe");
    applyStimulus(0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("fwd_r0");

    applyStimulus(0, 7, 0, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
    cycle("loaduse");
    applyStimulus(0, 7, 0, 1, 0, 0, 0, 1, 1, 7, 0, 0, 0);
    checkOutput("load_in_mem");
    cmp("load_in_mem.const_fwdb", 32'(fwdb), 3);
    cmp("load_in_mem.const_cnt", 32'(stall_cnt), 1);
    advance();

    applyStimulus(3, 0, 1, 0, 1, 0, 3, 1, 0, 3, 0, 0, 0);
    cycle("exe_priority");

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle("mdu_c0");
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (c >= 4 && c <= 9));
      checkOutput($sformatf("mdu_c%0d", c));
      if (c == 8) cmp("mdu_c8.const_done", 32'(mdu_done), 1);
      if (c == 9) cmp("mdu_c9.const_wpcir", 32'(wpcir), 1);
      advance();
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle("branch_flush");
    applyStimulus(4, 0, 1, 0, 1, 1, 4, 0, 0, 0, 1, 0, 0);
    cycle("branch_stalled");

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle("abort_c0");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("abort_c1");
    cycle("abort_c2");
    checkOutput("abort_c3");
    clrn = 1'b0;
    checkOutput("abort_reset");
    advance();
    clrn = 1'b1;
    cycle("abort_after");

    applyStimulus(9, 0, 1, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle("sat_hold");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat");
    cmp("sat.const_cnt", 32'(stall_cnt), SAT);
    advance();

    for (int i = 0; i < 400; i++) begin
      clrn = ($urandom_range(0, 63) != 0);
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      cycle("random");
    end
    clrn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
